pipelined_adder: RTL and testbench

Parametrised, pipelined WIDTH-bit add/subtract unit with valid/ready handshake. Operands are split into STAGES equal chunks. Each pipeline stage resolves one chunk and registers its carry into the next stage, so the critical path is one chunk-wide carry chain. It serves the traffic controller's timer and counter datapaths: phase-duration sums, countdown decrements and offset arithmetic, at one result per cycle.

---
 rtl/pipelined_adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 27 ++
 rtl/pipelined_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the timer/counter add-subtract datapath:
// operation-mode encodings, default geometry and the one-bit full adder cell.
package pipelined_adder_pkg;

    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Full adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple-carry adder built from the package full adder cell.
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    always_comb begin
        logic       carry;
        logic [1:0] fa;
        s     = '0;
        carry = ci;
        for (int i = 0; i < CW; i++) begin
            fa    = full_add(a[i], b[i], carry);
            s[i]  = fa[0];
            carry = fa[1];
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit: one CW-bit chunk per stage, carries
// registered between stages, operand skew on the way in and result deskew on the way out.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipelined_adder: WIDTH (%0d) must split evenly into STAGES (%0d)", WIDTH, STAGES);
    end

    logic              advance;
    logic              accept;
    logic              c0;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] carry_w;

    // Handshake: a word moves across a boundary only when valid && ready are both 1
    // on the same rising edge; the whole pipe stalls as one unit when the output is held.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = v_q[STAGES-1];
    assign ld        = vin & {STAGES{advance}};

    assign b_eff = (sub == ADD_MODE) ? b : ~b;
    assign c0    = (sub == SUB_MODE) ? ~cin : cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else if (advance) begin
            v_q <= vin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0] ca;
        logic [CW-1:0] cb;
        logic [CW-1:0] s_comb;
        logic          ci;
        logic          co_comb;
        logic          carry_r;
        logic [CW-1:0] dsk [0:STAGES-1-k];

        if (k == 0) begin : g_first
            assign vin[k] = accept;
            assign ci     = c0;
            assign ca     = a[CW-1:0];
            assign cb     = b_eff[CW-1:0];
        end else begin : g_skew
            // Chunk k operands ride k registers so they meet the carry from stage k-1.
            logic [CW-1:0] ska [1:k];
            logic [CW-1:0] skb [1:k];

            assign vin[k] = v_q[k-1];
            assign ci     = carry_w[k-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 1; d <= k; d++) begin
                        ska[d] <= '0;
                        skb[d] <= '0;
                    end
                end else begin
                    if (ld[0]) begin
                        ska[1] <= a[k*CW +: CW];
                        skb[1] <= b_eff[k*CW +: CW];
                    end
                    for (int d = 2; d <= k; d++) begin
                        if (ld[d-1]) begin
                            ska[d] <= ska[d-1];
                            skb[d] <= skb[d-1];
                        end
                    end
                end
            end

            assign ca = ska[k];
            assign cb = skb[k];
        end

        adder_chunk #(.CW(CW)) u_chunk (
            .a  (ca),
            .b  (cb),
            .ci (ci),
            .s  (s_comb),
            .co (co_comb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_r <= 1'b0;
            end else if (ld[k]) begin
                carry_r <= co_comb;
            end
        end

        assign carry_w[k] = carry_r;

        // dsk[0] is the stage register; the rest hold the chunk until the last stage catches up.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int e = 0; e <= STAGES-1-k; e++) begin
                    dsk[e] <= '0;
                end
            end else begin
                if (ld[k]) begin
                    dsk[0] <= s_comb;
                end
                for (int e = 1; e <= STAGES-1-k; e++) begin
                    if (ld[k+e]) begin
                        dsk[e] <= dsk[e-1];
                    end
                end
            end
        end

        assign sum[k*CW +: CW] = dsk[STAGES-1-k];

        if (k == STAGES-1) begin : g_last
            logic ovf_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (ld[k]) begin
                    ovf_r <= (ca[CW-1] == cb[CW-1]) && (s_comb[CW-1] != ca[CW-1]);
                end
            end

            assign ovf = ovf_r;
        end
    end

    assign cout = carry_w[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: STAGES=4 main instance plus STAGES=1 and
// STAGES=16 instances for latency and bit-exactness at the parameter extremes.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid4, in_valid1, in_valid16;
    logic        ir4, ir1, ir16;
    logic [15:0] a_in, b_in;
    logic        cin_in, sub_in;
    logic        out_ready;
    logic        ov4, ov1, ov16;
    logic [15:0] sum4, sum1, sum16;
    logic        cout4, cout1, cout16;
    logic        ovf4, ovf1, ovf16;

    int          checks = 0;
    int          errors = 0;
    int          dsel;
    logic [17:0] exp_q[$];

    logic        sel_ov, sel_ir, sel_cout, sel_ovf;
    logic [15:0] sel_sum;

    int          c, wi, got;
    logic [15:0] held, ta, tb;
    logic        tc, ts;
    logic [17:0] m;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(ir4),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ov4), .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(ir1),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir16),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    assign sel_ov   = (dsel == 0) ? ov4   : (dsel == 1) ? ov1   : ov16;
    assign sel_ir   = (dsel == 0) ? ir4   : (dsel == 1) ? ir1   : ir16;
    assign sel_sum  = (dsel == 0) ? sum4  : (dsel == 1) ? sum1  : sum16;
    assign sel_cout = (dsel == 0) ? cout4 : (dsel == 1) ? cout1 : cout16;
    assign sel_ovf  = (dsel == 0) ? ovf4  : (dsel == 1) ? ovf1  : ovf16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic on whole words: returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yp;
        logic        cz;
        logic [16:0] r;
        logic        v;
        yp = sb ? ~y : y;
        cz = sb ? ~ci : ci;
        r  = {1'b0, x} + {1'b0, yp} + {16'd0, cz};
        v  = (x[15] == yp[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated word; latency counts rising edges starting with the accepting edge.
    task automatic op(input int sel, input logic [15:0] oa, input logic [15:0] ob,
                      input logic oc, input logic os, input logic [15:0] es,
                      input logic ec, input logic eo, input int elat, input string tag);
        int cnt;
        dsel       = sel;
        a_in       = oa;
        b_in       = ob;
        cin_in     = oc;
        sub_in     = os;
        in_valid4  = (sel == 0);
        in_valid1  = (sel == 1);
        in_valid16 = (sel == 2);
        #1;
        chk({tag, " in_ready"}, {31'd0, sel_ir}, 32'd1);
        step();
        in_valid4  = 1'b0;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        cnt = 1;
        while (!sel_ov && cnt < 40) begin
            step();
            cnt++;
        end
        chk({tag, " latency"}, cnt, elat);
        chk({tag, " sum"}, {16'd0, sel_sum}, {16'd0, es});
        chk({tag, " cout"}, {31'd0, sel_cout}, {31'd0, ec});
        chk({tag, " ovf"}, {31'd0, sel_ovf}, {31'd0, eo});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid4  = 1'b0;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        a_in       = '0;
        b_in       = '0;
        cin_in     = 1'b0;
        sub_in     = 1'b0;
        out_ready  = 1'b1;
        dsel       = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("reset out_valid", {31'd0, ov4}, 32'd0);
        chk("reset sum", {16'd0, sum4}, 32'd0);
        chk("reset cout", {31'd0, cout4}, 32'd0);
        chk("reset ovf", {31'd0, ovf4}, 32'd0);
        chk("reset in_ready", {31'd0, ir4}, 32'd1);
        rst = 1'b0;
        step();
        chk("post reset in_ready", {31'd0, ir4}, 32'd1);

        // Directed vectors, STAGES=4
        op(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 4, "basic add");
        op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "carry chain");
        op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "signed ovf");
        op(0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4, "sub borrow");
        op(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 4, "sub no borrow");
        op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "sub ovf");
        op(0, 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 4, "add cin");

        // Backpressure: 8 back-to-back words, out_ready low for cycles 6..8
        dsel = 0;
        c    = 0;
        wi   = 0;
        got  = 0;
        exp_q.delete();
        while (got < 8 && c < 60) begin
            out_ready = !(c >= 6 && c <= 8);
            if (wi < 8) begin
                in_valid4 = 1'b1;
                a_in      = 16'(wi * 16'h1111);
                b_in      = 16'h0F0F;
                sub_in    = wi[0];
                cin_in    = wi[1];
            end else begin
                in_valid4 = 1'b0;
            end
            #1;
            if (c >= 6 && c <= 8) begin
                chk("bp stall in_ready", {31'd0, ir4}, 32'd0);
                chk("bp stall out_valid", {31'd0, ov4}, 32'd1);
                if (c == 6) held = sum4;
                else chk("bp stall sum held", {16'd0, sum4}, {16'd0, held});
            end
            if (ov4 && out_ready) begin
                chk("bp result pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    chk("bp result", {14'd0, ovf4, cout4, sum4}, {14'd0, m});
                end
                got++;
            end
            if (in_valid4 && ir4) begin
                exp_q.push_back(model(a_in, b_in, cin_in, sub_in));
                wi++;
            end
            step();
            c++;
        end
        in_valid4 = 1'b0;
        out_ready = 1'b1;
        chk("bp received count", got, 8);
        chk("bp queue drained", exp_q.size(), 0);
        #1;
        chk("bp no duplicate", {31'd0, ov4}, 32'd0);
        step();

        // Reset mid-flight: three words in, asynchronous pulse between edges
        for (int i = 0; i < 3; i++) begin
            in_valid4 = 1'b1;
            a_in      = 16'(16'h0100 * (i + 1));
            b_in      = 16'h0011;
            cin_in    = 1'b0;
            sub_in    = 1'b0;
            step();
        end
        in_valid4 = 1'b0;
        step();
        chk("midrst word in flight", {31'd0, ov4}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid drop", {31'd0, ov4}, 32'd0);
        chk("midrst sum cleared", {16'd0, sum4}, 32'd0);
        chk("midrst in_ready", {31'd0, ir4}, 32'd1);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst no stale", {31'd0, ov4}, 32'd0);
        end
        op(0, 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, 4, "post midrst");

        // STAGES=1 and STAGES=16
        op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "s1 carry");
        op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16, "s16 ovf");
        op(2, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16, "s16 borrow");
        for (int i = 0; i < 6; i++) begin
            ta = 16'($urandom_range(0, 65535));
            tb = 16'($urandom_range(0, 65535));
            tc = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            m  = model(ta, tb, tc, ts);
            op(1, ta, tb, tc, ts, m[15:0], m[16], m[17], 1, "s1 rand");
            ta = 16'($urandom_range(0, 65535));
            tb = 16'($urandom_range(0, 65535));
            tc = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            m  = model(ta, tb, tc, ts);
            op(2, ta, tb, tc, ts, m[15:0], m[16], m[17], 16, "s16 rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
